pwm_multi_output: RTL and testbench

PWM_MULTI_OUTPUT -- requirements
Module: pwm_multi_output

---
 rtl/pwm_multi_output.sv | 124 ++++++++++++
 tb/tb_pwm_multi_output.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_output.sv
// pwm_multi_output: CHANNELS independent PWM outputs driven by one shared
// period counter. Period and duty values are double-buffered. A load writes
// the pending set. The pending set becomes active only at a period boundary
// or while en is low, so every period uses one consistent set of values.
//
// Optional feature: define PWM_CENTER_ALIGNED_EN to get up/down
// (center-aligned) counting. The count then runs 0..P..1 and the period is
// 2P cycles. Without the macro the counter is edge-aligned: 0..P-1, period P.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   en             counting enable; when low, cnt is held at 0 and outputs are low
//   load           one-cycle strobe that captures period_in/duty_in as pending
//   period_in      requested period P (WIDTH bits)
//   duty_in        channel i duty D[i] in bits [i*WIDTH +: WIDTH]
//   pwm            registered outputs; high while cnt < D[i]
//   period_end     registered one-cycle pulse in the last cycle of a period
//   update_pending high while loaded values wait for a boundary
module pwm_multi_output #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_end,
  output logic                      update_pending
);

  logic [WIDTH-1:0]          cnt, cnt_nxt;
  logic [WIDTH-1:0]          act_p, pend_p, new_p;
  logic [CHANNELS*WIDTH-1:0] act_d, pend_d, new_d;
  logic                      run_q;
  logic                      start, transfer, active;
  logic                      period_end_nxt;
  logic [CHANNELS-1:0]       pwm_nxt;

  // The next cycle begins a fresh period if one of three things holds:
  // the previous cycle was not counting, the previous cycle was the last
  // of its period, or an idle P=0 is active. Pending values are applied on
  // a period start and on every cycle while en is low. A load arriving on
  // the same edge bypasses straight into the active set.
  always_comb begin
    start    = !run_q || period_end || (act_p == '0);
    transfer = !en || start;
    new_p    = act_p;
    new_d    = act_d;
    if (transfer) begin
      new_p = load ? period_in : pend_p;
      new_d = load ? duty_in   : pend_d;
    end
    active = en && (new_p != '0);
  end

`ifdef PWM_CENTER_ALIGNED_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  dir_t dir, dir_nxt;

  always_comb begin
    cnt_nxt = '0;
    dir_nxt = DIR_UP;
    if (active && !start) begin
      cnt_nxt = (dir == DIR_DOWN) ? cnt - 1'b1 : cnt + 1'b1;
      dir_nxt = (cnt_nxt == new_p) ? DIR_DOWN : dir;
    end
    // The last element of the sequence is the count of 1 on the way down.
    // With P=1 the count reaches 1 going up, and the direction is already
    // switched to DOWN at that point.
    period_end_nxt = active && (cnt_nxt == WIDTH'(1)) && (dir_nxt == DIR_DOWN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir <= DIR_UP;
    else     dir <= dir_nxt;
  end
`else
  always_comb begin
    cnt_nxt = '0;
    if (active && !start) cnt_nxt = cnt + 1'b1;
    period_end_nxt = active && (cnt_nxt == new_p - 1'b1);
  end
`endif

  // The outputs are registered from the next-state count and the duty
  // values. As a result, pwm lines up with the cnt of the same cycle.
  always_comb begin
    pwm_nxt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      pwm_nxt[i] = active && (cnt_nxt < new_d[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      act_p          <= '0;
      act_d          <= '0;
      pend_p         <= '0;
      pend_d         <= '0;
      run_q          <= 1'b0;
      pwm            <= '0;
      period_end     <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      act_p      <= new_p;
      act_d      <= new_d;
      run_q      <= en;
      pwm        <= pwm_nxt;
      period_end <= period_end_nxt;
      if (load) begin
        pend_p <= period_in;
        pend_d <= duty_in;
      end
      if (transfer)  update_pending <= 1'b0;
      else if (load) update_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_multi_output.sv
module tb_pwm_multi_output;
  localparam int unsigned CH = 2;
  localparam int unsigned W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            load = 1'b0;
  logic [W-1:0]    period_in = '0;
  logic [CH*W-1:0] duty_in = '0;
  logic [CH-1:0]   pwm;
  logic            period_end;
  logic            update_pending;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  pwm_multi_output #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .period_in(period_in),
    .duty_in(duty_in), .pwm(pwm), .period_end(period_end),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  // Reference model. It tracks the position inside the current period as
  // an index, using plain 64-bit arithmetic.
  longint unsigned m_p, m_pp, m_idx;
  longint unsigned m_d [CH];
  longint unsigned m_pd[CH];
  bit m_pend, m_run;

  function automatic longint unsigned plen(longint unsigned p);
`ifdef PWM_CENTER_ALIGNED_EN
    return 2 * p;
`else
    return p;
`endif
  endfunction

  function automatic longint unsigned cnt_of(longint unsigned idx, longint unsigned p);
`ifdef PWM_CENTER_ALIGNED_EN
    return (idx <= p) ? idx : 2 * p - idx;
`else
    return idx;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p = 0; m_pp = 0; m_idx = 0; m_pend = 0; m_run = 0;
      for (int i = 0; i < CH; i++) begin m_d[i] = 0; m_pd[i] = 0; end
    end else begin
      bit boundary;
      boundary = !m_run || m_p == 0 || m_idx == plen(m_p) - 1;
      if (load) begin
        m_pp = period_in;
        for (int i = 0; i < CH; i++) m_pd[i] = duty_in[i*W +: W];
        m_pend = 1;
      end
      if (!en || boundary) begin
        m_p = m_pp;
        for (int i = 0; i < CH; i++) m_d[i] = m_pd[i];
        m_pend = 0;
        m_idx  = 0;
      end else begin
        m_idx = m_idx + 1;
      end
      m_run = en;
    end
  end

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [CH-1:0] e_pwm;
      bit on;
      on = m_run && m_p != 0;
      for (int i = 0; i < CH; i++) e_pwm[i] = on && (cnt_of(m_idx, m_p) < m_d[i]);
      check("model_pwm", pwm, e_pwm);
      check("model_period_end", period_end, on && m_idx == plen(m_p) - 1);
      check("model_update_pending", update_pending, m_pend);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(int p, int d0, int d1);
    period_in = W'(p);
    duty_in   = {W'(d1), W'(d0)};
    load = 1'b1;
  endtask

  // Advances until period_end is seen, counting the cycle length and the
  // number of high cycles on each channel.
  task automatic period_stats(output int len, output int h0, output int h1);
    len = 0; h0 = 0; h1 = 0;
    do begin
      tick();
      load = 1'b0;
      len++;
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end while (!period_end && len < 600);
    check("period_end_seen", period_end, 1);
  endtask

  int len, h0, h1, c0, c1;

  initial begin
    #12;
    check("reset_pwm", pwm, 0);
    check("reset_period_end", period_end, 0);
    check("reset_update_pending", update_pending, 0);
    tick();
    rst = 1'b0;
    chk_on = 1'b1;
    en = 1'b1;

    // P=10, D={3,7}
    do_load(10, 3, 7);
    period_stats(len, h0, h1);
    period_stats(len, h0, h1);
    check("p10_len", len, 10); check("p10_h0", h0, 3); check("p10_h1", h1, 7);
    period_stats(len, h0, h1);
    check("p10_len2", len, 10); check("p10_h0_2", h0, 3); check("p10_h1_2", h1, 7);

    // Mid-period reload to P=4, D={1,4}
    tick(); tick(); tick();
    do_load(4, 1, 4);
    tick();
    load = 1'b0;
    check("midload_pending", update_pending, 1);
    period_stats(len, h0, h1);
    check("midload_rest_of_period", len + 4, 10);
    period_stats(len, h0, h1);
    check("p4_len", len, 4); check("p4_h0", h0, 1); check("p4_h1", h1, 4);

    // Load on the period_end cycle: applies to the very next period
    do_load(6, 2, 6);
    period_stats(len, h0, h1);
    check("coincident_len", len, 6); check("coincident_h0", h0, 2); check("coincident_h1", h1, 6);

    // D={0,255}, P=255
    do_load(255, 0, 255);
    period_stats(len, h0, h1);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      c0 += int'(pwm[0]); c1 += int'(pwm[1]);
    end
    check("full_scale_h0", c0, 0);
    check("full_scale_h1", c1, 1000);

    // Async reset at cnt=5
    do_load(10, 3, 7);
    period_stats(len, h0, h1);
    period_stats(len, h0, h1);
    check("p10_again_len", len, 10);
    repeat (6) tick();
    check("cnt5_pwm1_high", pwm[1], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_period_end", period_end, 0);
    check("async_rst_pending", update_pending, 0);
    tick();
    rst = 1'b0;
    c0 = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      c0 += int'(pwm != 0) + int'(period_end) + int'(update_pending);
    end
    check("post_reset_idle", c0, 0);

    // Randomised traffic
    for (int k = 0; k < 4000; k++) begin
      int r, p;
      en   = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      p = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 255 : $urandom_range(2, 12);
      period_in = W'(p);
      for (int i = 0; i < CH; i++) begin
        int d;
        d = $urandom_range(0, p + 2);
        duty_in[i*W +: W] = W'((d > 255) ? 255 : d);
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
